// File: rtl/mc_controller_seq.sv
// Multicycle control unit for NITC-RISC24: main FSM, ALU decode and PC enable.
// Handles memory wait states, LM/SM register-mask sequencing and illegal-opcode trap.
module mc_controller_seq #(
    parameter int OP_W  = 4,
    parameter int ALU_W = 3,
    parameter int NREG  = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OP_W-1:0]  op,
    input  logic             compare,
    input  logic             mem_ready,
    input  logic [NREG-1:0]  mask,
    output logic             pcen,
    output logic             memread,
    output logic             memwrite,
    output logic             irwrite,
    output logic             regwrite,
    output logic             alusrca,
    output logic             iord,
    output logic             memtoreg,
    output logic             regdst,
    output logic [1:0]       alusrcb,
    output logic [1:0]       pcsrc,
    output logic [ALU_W-1:0] alucontrol,
    output logic             addr_step,
    output logic [IDX_W-1:0] lmsm_idx,
    output logic             illegal,
    output logic [4:0]       state
);

    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(4'b0000);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(4'b0001);
    localparam logic [OP_W-1:0] OP_NAND = OP_W'(4'b0010);
    localparam logic [OP_W-1:0] OP_LW   = OP_W'(4'b0100);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(4'b0101);
    localparam logic [OP_W-1:0] OP_LM   = OP_W'(4'b0110);
    localparam logic [OP_W-1:0] OP_SM   = OP_W'(4'b0111);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(4'b1000);
    localparam logic [OP_W-1:0] OP_JAL  = OP_W'(4'b1001);
    localparam logic [OP_W-1:0] OP_JLR  = OP_W'(4'b1010);

    localparam logic [ALU_W-1:0] ALU_ADD  = ALU_W'(3'b000);
    localparam logic [ALU_W-1:0] ALU_SUB  = ALU_W'(3'b001);
    localparam logic [ALU_W-1:0] ALU_NAND = ALU_W'(3'b010);

    typedef enum logic [4:0] {
        S_FETCH    = 5'd0,
        S_DECODE   = 5'd1,
        S_RTEXE    = 5'd2,
        S_RTWB     = 5'd3,
        S_ITEXE    = 5'd4,
        S_ITWB     = 5'd5,
        S_MEMADR   = 5'd6,
        S_MEMRD    = 5'd7,
        S_MEMWB    = 5'd8,
        S_MEMWR    = 5'd9,
        S_BEQ      = 5'd10,
        S_JAL      = 5'd11,
        S_JLR      = 5'd12,
        S_LMSM_ADR = 5'd13,
        S_LMSM_RD  = 5'd14,
        S_LMSM_WB  = 5'd15,
        S_LMSM_WR  = 5'd16,
        S_ILL      = 5'd17
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [NREG-1:0] mask_r;
    logic [NREG-1:0] mask_s;
    logic [NREG-1:0] mask_clr_s;
    logic            pcwrite_s;
    logic            branch_s;

    // Index of the lowest set bit; LM/SM transfers go in ascending register order.
    function automatic logic [IDX_W-1:0] lowest_idx(input logic [NREG-1:0] m);
        logic [IDX_W-1:0] idx;
        idx = {IDX_W{1'b0}};
        for (int i = NREG - 1; i >= 0; i--) begin
            if (m[i]) begin
                idx = IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    assign mask_clr_s = mask_r & (mask_r - {{(NREG-1){1'b0}}, 1'b1});

    // State and LM/SM mask registers; reset aborts any transfer in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_FETCH;
            mask_r  <= {NREG{1'b0}};
        end else begin
            state_r <= state_s;
            mask_r  <= mask_s;
        end
    end

    // Next-state and mask sequencing.
    always_comb begin
        state_s = state_r;
        mask_s  = mask_r;
        case (state_r)
            S_FETCH: begin
                if (mem_ready) begin
                    state_s = S_DECODE;
                end else begin
                    state_s = S_FETCH;
                end
            end
            S_DECODE: begin
                mask_s = mask;
                case (op)
                    OP_ADD, OP_NAND: state_s = S_RTEXE;
                    OP_ADDI:         state_s = S_ITEXE;
                    OP_LW, OP_SW:    state_s = S_MEMADR;
                    OP_LM, OP_SM:    state_s = S_LMSM_ADR;
                    OP_BEQ:          state_s = S_BEQ;
                    OP_JAL:          state_s = S_JAL;
                    OP_JLR:          state_s = S_JLR;
                    default:         state_s = S_ILL;
                endcase
            end
            S_RTEXE:  state_s = S_RTWB;
            S_ITEXE:  state_s = S_ITWB;
            S_MEMADR: begin
                if (op == OP_SW) begin
                    state_s = S_MEMWR;
                end else begin
                    state_s = S_MEMRD;
                end
            end
            S_MEMRD: begin
                if (mem_ready) begin
                    state_s = S_MEMWB;
                end else begin
                    state_s = S_MEMRD;
                end
            end
            S_MEMWR: begin
                if (mem_ready) begin
                    state_s = S_FETCH;
                end else begin
                    state_s = S_MEMWR;
                end
            end
            S_LMSM_ADR: begin
                if (mask_r == {NREG{1'b0}}) begin
                    state_s = S_FETCH;
                end else if (op == OP_SM) begin
                    state_s = S_LMSM_WR;
                end else begin
                    state_s = S_LMSM_RD;
                end
            end
            S_LMSM_RD: begin
                if (mem_ready) begin
                    state_s = S_LMSM_WB;
                end else begin
                    state_s = S_LMSM_RD;
                end
            end
            S_LMSM_WB: begin
                mask_s = mask_clr_s;
                if (mask_clr_s == {NREG{1'b0}}) begin
                    state_s = S_FETCH;
                end else begin
                    state_s = S_LMSM_RD;
                end
            end
            S_LMSM_WR: begin
                if (!mem_ready) begin
                    state_s = S_LMSM_WR;
                end else if (mask_clr_s == {NREG{1'b0}}) begin
                    mask_s  = mask_clr_s;
                    state_s = S_FETCH;
                end else begin
                    mask_s  = mask_clr_s;
                    state_s = S_LMSM_WR;
                end
            end
            S_RTWB, S_ITWB, S_MEMWB, S_BEQ, S_JAL, S_JLR, S_ILL: state_s = S_FETCH;
            default: state_s = S_FETCH;
        endcase
    end

    // Datapath control decode; only FETCH and LMSM_WR strobes wait on mem_ready.
    always_comb begin
        memread    = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = ALU_ADD;
        addr_step  = 1'b0;
        illegal    = 1'b0;
        pcwrite_s  = 1'b0;
        branch_s   = 1'b0;
        case (state_r)
            S_FETCH: begin
                memread   = 1'b1;
                alusrcb   = 2'b01;
                irwrite   = mem_ready;
                pcwrite_s = mem_ready;
            end
            S_DECODE: alusrcb = 2'b11;
            S_RTEXE: begin
                alusrca = 1'b1;
                if (op == OP_NAND) begin
                    alucontrol = ALU_NAND;
                end else begin
                    alucontrol = ALU_ADD;
                end
            end
            S_RTWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            S_ITEXE, S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ITWB: regwrite = 1'b1;
            S_MEMRD, S_LMSM_RD: begin
                memread = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            S_MEMWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            S_BEQ: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                branch_s   = 1'b1;
                pcsrc      = 2'b01;
            end
            S_JAL: begin
                regwrite  = 1'b1;
                pcwrite_s = 1'b1;
                pcsrc     = 2'b10;
            end
            S_JLR: begin
                regwrite  = 1'b1;
                pcwrite_s = 1'b1;
                pcsrc     = 2'b11;
            end
            S_LMSM_ADR: alusrca = 1'b1;
            S_LMSM_WB: begin
                regwrite  = 1'b1;
                memtoreg  = 1'b1;
                addr_step = 1'b1;
            end
            S_LMSM_WR: begin
                memwrite  = 1'b1;
                iord      = 1'b1;
                addr_step = mem_ready;
            end
            S_ILL: illegal = 1'b1;
            default: illegal = 1'b0;
        endcase
    end

    assign pcen     = pcwrite_s | (branch_s & compare);
    assign lmsm_idx = lowest_idx(mask_r);
    assign state    = state_r;

endmodule

// File: tb/tb_mc_controller_seq.sv
// Randomised scoreboard bench for mc_controller_seq: per-instruction expected output
// sequences are queued by the stimulus and compared cycle by cycle by a monitor.
module tb_mc_controller_seq;

    typedef struct packed {
        logic       pcen;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       alusrca;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] alucontrol;
        logic       addr_step;
        logic [2:0] lmsm_idx;
        logic       illegal;
    } outs_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] op;
    logic       compare;
    logic       mem_ready;
    logic [7:0] mask;
    logic       pcen, memread, memwrite, irwrite, regwrite;
    logic       alusrca, iord, memtoreg, regdst, addr_step, illegal;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol, lmsm_idx;
    logic [4:0] state;
    outs_t      act;

    outs_t      exp_q[$];
    outs_t      mon_e;
    logic [7:0] m_model;
    logic [3:0] pend_op;
    logic [7:0] pend_mask;
    logic       pend_cmp;
    bit         pend_ld;
    string      cur_name;
    int         n_chk;
    int         n_fail;

    mc_controller_seq dut (
        .clk(clk), .reset(reset), .op(op), .compare(compare), .mem_ready(mem_ready), .mask(mask),
        .pcen(pcen), .memread(memread), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
        .alusrca(alusrca), .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrcb(alusrcb),
        .pcsrc(pcsrc), .alucontrol(alucontrol), .addr_step(addr_step), .lmsm_idx(lmsm_idx),
        .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    assign act = {pcen, memread, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
                  alusrcb, pcsrc, alucontrol, addr_step, lmsm_idx, illegal};

    function automatic logic [2:0] low_idx(input logic [7:0] m);
        for (int i = 0; i < 8; i++) begin
            if (m[i]) return 3'(i);
        end
        return 3'd0;
    endfunction

    function automatic outs_t base();
        outs_t o;
        o = '0;
        o.lmsm_idx = low_idx(m_model);
        return o;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic check(input string name, input outs_t a, input outs_t e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s [%s] t=%0t: got %h expected %h (state=%0d)", name, cur_name, $time, a, e, state);
        end
    endtask

    // Monitor: one expected vector per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("cycle", act, mon_e);
        end
    end

    task automatic cyc(input logic mr, input outs_t e);
        @(posedge clk);
        #1;
        if (pend_ld) begin
            op      = pend_op;
            mask    = pend_mask;
            compare = pend_cmp;
            pend_ld = 1'b0;
        end
        mem_ready = mr;
        exp_q.push_back(e);
    endtask

    task automatic access(input outs_t e, input outs_t last, input int st);
        int n;
        n = (st < 0) ? int'($urandom_range(0, 3)) : st;
        repeat (n) cyc(1'b0, e);
        cyc(1'b1, last);
    endtask

    task automatic fetch_decode(input logic [3:0] o, input logic [7:0] mk, input logic c);
        outs_t e;
        int    nf;
        pend_op = o; pend_mask = mk; pend_cmp = c; pend_ld = 1'b1;
        nf = int'($urandom_range(0, 2));
        e = base(); e.memread = 1'b1; e.alusrcb = 2'b01;
        repeat (nf) cyc(1'b0, e);
        e.irwrite = 1'b1; e.pcen = 1'b1;
        cyc(1'b1, e);
        e = base(); e.alusrcb = 2'b11;
        cyc(rb(), e);
        m_model = mk;
    endtask

    task automatic run_instr(input logic [3:0] o, input logic [7:0] mk, input logic c, input int st);
        outs_t e, l;
        fetch_decode(o, mk, c);
        case (o)
            4'b0000, 4'b0010: begin
                e = base(); e.alusrca = 1'b1; e.alucontrol = (o == 4'b0010) ? 3'b010 : 3'b000;
                cyc(rb(), e);
                e = base(); e.regwrite = 1'b1; e.regdst = 1'b1;
                cyc(rb(), e);
            end
            4'b0001: begin
                e = base(); e.alusrca = 1'b1; e.alusrcb = 2'b10;
                cyc(rb(), e);
                e = base(); e.regwrite = 1'b1;
                cyc(rb(), e);
            end
            4'b0100, 4'b0101: begin
                e = base(); e.alusrca = 1'b1; e.alusrcb = 2'b10;
                cyc(rb(), e);
                e = base(); e.iord = 1'b1;
                if (o == 4'b0100) begin
                    e.memread = 1'b1;
                    access(e, e, st);
                    e = base(); e.regwrite = 1'b1; e.memtoreg = 1'b1;
                    cyc(rb(), e);
                end else begin
                    e.memwrite = 1'b1;
                    access(e, e, st);
                end
            end
            4'b0110, 4'b0111: begin
                e = base(); e.alusrca = 1'b1;
                cyc(rb(), e);
                while (m_model != 8'd0) begin
                    e = base(); e.iord = 1'b1;
                    if (o == 4'b0110) begin
                        e.memread = 1'b1;
                        access(e, e, st);
                        e = base(); e.regwrite = 1'b1; e.memtoreg = 1'b1; e.addr_step = 1'b1;
                        cyc(rb(), e);
                    end else begin
                        e.memwrite = 1'b1;
                        l = e; l.addr_step = 1'b1;
                        access(e, l, st);
                    end
                    m_model = m_model & (m_model - 8'd1);
                end
            end
            4'b1000: begin
                e = base(); e.alusrca = 1'b1; e.alucontrol = 3'b001; e.pcsrc = 2'b01; e.pcen = c;
                cyc(rb(), e);
            end
            4'b1001, 4'b1010: begin
                e = base(); e.regwrite = 1'b1; e.pcen = 1'b1;
                e.pcsrc = (o == 4'b1001) ? 2'b10 : 2'b11;
                cyc(rb(), e);
            end
            default: begin
                e = base(); e.illegal = 1'b1;
                cyc(rb(), e);
            end
        endcase
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() > 0 && k < 20) begin
            @(posedge clk);
            k++;
        end
        @(negedge clk);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected cycles left unchecked, required 0", exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        outs_t e;
        n_chk = 0; n_fail = 0; pend_ld = 1'b0; m_model = 8'd0;
        reset = 1'b0; op = 4'd0; mask = 8'd0; compare = 1'b0; mem_ready = 1'b0;
        cur_name = "reset";
        #7;
        e = base(); e.memread = 1'b1; e.alusrcb = 2'b01;
        check("reset_state", act, e);
        #5 reset = 1'b1;

        cur_name = "ADD";      run_instr(4'b0000, 8'h3C, 1'b0, 0);
        cur_name = "NAND";     run_instr(4'b0010, 8'h00, 1'b1, 0);
        cur_name = "ADDI";     run_instr(4'b0001, 8'h81, 1'b0, 0);
        cur_name = "LW_wait3"; run_instr(4'b0100, 8'h10, 1'b0, 3);
        cur_name = "SW_wait2"; run_instr(4'b0101, 8'h02, 1'b0, 2);
        cur_name = "BEQ_eq";   run_instr(4'b1000, 8'h00, 1'b1, 0);
        cur_name = "BEQ_ne";   run_instr(4'b1000, 8'h00, 1'b0, 0);
        cur_name = "JAL";      run_instr(4'b1001, 8'h00, 1'b1, 0);
        cur_name = "JLR";      run_instr(4'b1010, 8'h00, 1'b0, 0);
        cur_name = "LM_85";    run_instr(4'b0110, 8'h85, 1'b0, 0);
        cur_name = "LM_00";    run_instr(4'b0110, 8'h00, 1'b0, 0);
        cur_name = "SM_85";    run_instr(4'b0111, 8'h85, 1'b1, 1);
        cur_name = "ILL_F";    run_instr(4'b1111, 8'h40, 1'b1, 0);
        cur_name = "ILL_3";    run_instr(4'b0011, 8'h00, 1'b1, 0);

        cur_name = "random";
        for (int i = 0; i < 80; i++) begin
            run_instr(4'($urandom_range(0, 15)),
                      ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom),
                      rb(), -1);
        end

        // Abort an SM in its write wait state with an asynchronous reset.
        cur_name = "SM_abort";
        fetch_decode(4'b0111, 8'h06, 1'b0);
        e = base(); e.alusrca = 1'b1;
        cyc(rb(), e);
        e = base(); e.memwrite = 1'b1; e.iord = 1'b1;
        cyc(1'b0, e);
        cyc(1'b0, e);
        @(negedge clk);
        #1 reset = 1'b0;
        m_model = 8'd0;
        #1;
        e = base(); e.memread = 1'b1; e.alusrcb = 2'b01;
        check("reset_abort", act, e);
        @(posedge clk);
        #1 check("reset_hold", act, e);
        @(negedge clk);
        #2 reset = 1'b1;

        cur_name = "post_abort_ADD"; run_instr(4'b0000, 8'h00, 1'b0, 0);
        cur_name = "post_abort_SM";  run_instr(4'b0111, 8'hA0, 1'b0, -1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
